// File: rtl/rf_transceiver_pkg.sv
// Shared definitions for the RF transceiver controller: byte width and the
// wireless transmit scheduler state encoding.
package rf_transceiver_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    SEND,
    GAP,
    DRAIN
  } wtx_state_e;

  // States in which the node is considered to be transmitting wirelessly.
  function automatic logic is_wtrans(wtx_state_e s);
    return s inside {SEND, GAP, DRAIN};
  endfunction

endpackage

// File: rtl/wireless_tx_scheduler_if.sv
// Byte paths around the scheduler: MCU UART receive side in, node UART
// transmit side out. master = surrounding UARTs, slave = scheduler.
interface wireless_tx_scheduler_if #(
  parameter int DATA_WIDTH = rf_transceiver_pkg::DATA_WIDTH
);
  logic                  rx_flag_mcu;
  logic [DATA_WIDTH-1:0] data_from_uart_mcu;
  logic                  tx_ready_node;
  logic                  tx_complete_node;
  logic                  tx_use_node;
  logic [DATA_WIDTH-1:0] data_to_uart_node;

  modport master (
    output rx_flag_mcu, data_from_uart_mcu, tx_ready_node, tx_complete_node,
    input  tx_use_node, data_to_uart_node
  );

  modport slave (
    input  rx_flag_mcu, data_from_uart_mcu, tx_ready_node, tx_complete_node,
    output tx_use_node, data_to_uart_node
  );
endinterface

// File: rtl/wtx_buffer_fifo.sv
// Synchronous byte FIFO buffering MCU data ahead of wireless transmission.
// Writes to a full FIFO are dropped; reads from an empty FIFO are ignored.
module wtx_buffer_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 512,
  parameter int CNT_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_WIDTH-1:0]  count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  assign full    = (count == CNT_WIDTH'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: storage has no reset; clearing the pointers and count is what
  // discards the contents, and it keeps the array mappable to RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/wireless_tx_scheduler.sv
// Buffers MCU bytes and drains them to the node UART in bursts, with an
// inter-packet gap. Define WTX_IDLE_FLUSH_EN to flush partial packets on idle.
module wireless_tx_scheduler #(
  parameter int DATA_WIDTH                  = rf_transceiver_pkg::DATA_WIDTH,
  parameter int BUFFER_DEPTH                = 512,
  parameter int CNT_WIDTH                   = 10,
  parameter int START_WIRELESS_TRANS_VALUE  = 58,
  parameter int END_WAITING_SEND_WLESS_DATA = 6250,
  parameter int END_INTER_PACKET_GAP        = 625
) (
  input  logic                 internal_clk,
  input  logic                 rst,
  input  logic                 trans_enable,
  wireless_tx_scheduler_if.slave bus,
  output logic                 wtrans_active,
  output logic                 aux_busy_n,
  output logic [CNT_WIDTH-1:0] buffer_count,
  output logic                 overflow
);
  import rf_transceiver_pkg::*;

  localparam int BURST_W = $clog2(START_WIRELESS_TRANS_VALUE + 1);
  localparam int GAP_W   = $clog2(END_INTER_PACKET_GAP + 1);

  wtx_state_e            state;
  wtx_state_e            state_next;
  logic [BURST_W-1:0]    burst_cnt;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  rd_en;
  logic                  burst_done;
  logic                  idle_expired;
  logic                  tx_use_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic [DATA_WIDTH-1:0] fifo_rd_data;

  wtx_buffer_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUFFER_DEPTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_fifo (
    .clk     (internal_clk),
    .rst     (rst),
    .wr_en   (bus.rx_flag_mcu),
    .wr_data (bus.data_from_uart_mcu),
    .rd_en   (rd_en),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (buffer_count)
  );

  assign burst_done = (burst_cnt == BURST_W'(START_WIRELESS_TRANS_VALUE));

  // The strobe of the previous cycle blocks a read so the UART ready flag
  // has a cycle to reflect the byte just written.
  assign rd_en = (state == SEND) && trans_enable && bus.tx_ready_node &&
                 !fifo_empty && !tx_use_q && !burst_done;

`ifdef WTX_IDLE_FLUSH_EN
  localparam int IDLE_W = $clog2(END_WAITING_SEND_WLESS_DATA + 1);
  logic [IDLE_W-1:0] idle_cnt;

  // Saturates so a disabled transmitter flushes as soon as it is re-enabled.
  always_ff @(posedge internal_clk) begin
    if (rst || bus.rx_flag_mcu || state != COLLECT)
      idle_cnt <= '0;
    else if (idle_cnt != IDLE_W'(END_WAITING_SEND_WLESS_DATA - 1))
      idle_cnt <= idle_cnt + 1'b1;
  end

  assign idle_expired = (state == COLLECT) &&
                        (idle_cnt == IDLE_W'(END_WAITING_SEND_WLESS_DATA - 1));
`else
  assign idle_expired = 1'b0;
`endif

  // NOTE: next state gets a default before the case so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:
        if (bus.rx_flag_mcu || !fifo_empty) state_next = COLLECT;
      COLLECT:
        if (trans_enable &&
            (buffer_count >= CNT_WIDTH'(START_WIRELESS_TRANS_VALUE) || idle_expired))
          state_next = SEND;
      SEND:
        if (!trans_enable || fifo_empty) state_next = DRAIN;
        else if (burst_done)             state_next = GAP;
      GAP:
        if (!trans_enable) state_next = DRAIN;
        else if (gap_cnt == GAP_W'(END_INTER_PACKET_GAP - 1)) state_next = SEND;
      DRAIN:
        if (bus.tx_complete_node) state_next = fifo_empty ? IDLE : COLLECT;
      default:
        state_next = IDLE;
    endcase
  end

  always_ff @(posedge internal_clk) begin
    if (rst) begin
      state         <= IDLE;
      tx_use_q      <= 1'b0;
      tx_data_q     <= '0;
      wtrans_active <= 1'b0;
      overflow      <= 1'b0;
      burst_cnt     <= '0;
      gap_cnt       <= '0;
    end else begin
      state         <= state_next;
      tx_use_q      <= rd_en;
      wtrans_active <= is_wtrans(state_next);
      if (rd_en) tx_data_q <= fifo_rd_data;
      if (bus.rx_flag_mcu && fifo_full) overflow <= 1'b1;
      if (state != SEND)  burst_cnt <= '0;
      else if (rd_en)     burst_cnt <= burst_cnt + 1'b1;
      if (state != GAP)   gap_cnt <= '0;
      else                gap_cnt <= gap_cnt + 1'b1;
    end
  end

  assign bus.tx_use_node       = tx_use_q;
  assign bus.data_to_uart_node = tx_data_q;
  assign aux_busy_n            = (state == IDLE) && (buffer_count == '0);
endmodule

// File: tb/tb_wireless_tx_scheduler.sv
// Scoreboard bench for wireless_tx_scheduler: stimulus pushes expected bytes,
// a negedge monitor pops and compares on every tx_use_node strobe.
module tb_wireless_tx_scheduler;
  localparam int START   = 58;
  localparam int IDLE_TO = 6250;
  localparam int GAP_LEN = 625;

  logic       internal_clk = 1'b0;
  logic       rst;
  logic       trans_enable;
  logic       wtrans_active;
  logic       aux_busy_n;
  logic [9:0] buffer_count;
  logic       overflow;

  wireless_tx_scheduler_if #(.DATA_WIDTH(8)) bus ();

  wireless_tx_scheduler #(
    .DATA_WIDTH                  (8),
    .BUFFER_DEPTH                (512),
    .CNT_WIDTH                   (10),
    .START_WIRELESS_TRANS_VALUE  (START),
    .END_WAITING_SEND_WLESS_DATA (IDLE_TO),
    .END_INTER_PACKET_GAP        (GAP_LEN)
  ) dut (
    .internal_clk  (internal_clk),
    .rst           (rst),
    .trans_enable  (trans_enable),
    .bus           (bus),
    .wtrans_active (wtrans_active),
    .aux_busy_n    (aux_busy_n),
    .buffer_count  (buffer_count),
    .overflow      (overflow)
  );

  always #5 internal_clk = ~internal_clk;

  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc         = 0;
  int         strobe_cnt  = 0;
  int         strobe_cyc[$];
  logic [7:0] exp_q[$];
  logic       prev_strobe = 1'b0;

  always @(posedge internal_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must carry the oldest outstanding expected byte.
  always @(negedge internal_clk) begin
    if (!rst && bus.tx_use_node) begin
      check("strobe_spacing", {31'b0, prev_strobe}, 32'd0);
      strobe_cnt++;
      strobe_cyc.push_back(cyc);
      if (exp_q.size() == 0) check("unexpected_strobe", strobe_cnt, 32'd0);
      else                   check("tx_data", bus.data_to_uart_node, exp_q.pop_front());
    end
    prev_strobe = bus.tx_use_node && !rst;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge internal_clk);
      #2;
    end
  endtask

  task automatic write_byte(input logic [7:0] b, input bit expect_out);
    bus.rx_flag_mcu        = 1'b1;
    bus.data_from_uart_mcu = b;
    if (expect_out) exp_q.push_back(b);
    tick(1);
    bus.rx_flag_mcu = 1'b0;
  endtask

  task automatic wait_strobes(input int target, input int budget, output int wtrans_low);
    int n;
    n = 0;
    wtrans_low = 0;
    while (strobe_cnt < target && n < budget) begin
      tick(1);
      n++;
      if (strobe_cnt < target && !wtrans_active) wtrans_low++;
    end
    check("strobe_timeout", {31'b0, strobe_cnt >= target}, 32'd1);
  endtask

  // Ends in IDLE: DRAIN is left by a one-cycle tx_complete_node pulse.
  task automatic finish_drain(input string tag);
    check({tag, "_drain_wtrans"}, {31'b0, wtrans_active}, 32'd1);
    check({tag, "_drain_busy"}, {31'b0, aux_busy_n}, 32'd0);
    bus.tx_complete_node = 1'b1;
    tick(1);
    bus.tx_complete_node = 1'b0;
    check({tag, "_idle_wtrans"}, {31'b0, wtrans_active}, 32'd0);
    check({tag, "_idle_busy"}, {31'b0, aux_busy_n}, 32'd1);
  endtask

  initial begin
    int base;
    int low;
    rst                    = 1'b1;
    trans_enable           = 1'b1;
    bus.rx_flag_mcu        = 1'b0;
    bus.data_from_uart_mcu = '0;
    bus.tx_ready_node      = 1'b1;
    bus.tx_complete_node   = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);

    // Reset values
    check("rst_tx_use", {31'b0, bus.tx_use_node}, 32'd0);
    check("rst_tx_data", {24'b0, bus.data_to_uart_node}, 32'd0);
    check("rst_wtrans", {31'b0, wtrans_active}, 32'd0);
    check("rst_busy_n", {31'b0, aux_busy_n}, 32'd1);
    check("rst_count", {22'b0, buffer_count}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);

    // Threshold burst: 58 bytes, one per 10 cycles
    base = strobe_cnt;
    for (int i = 0; i < START; i++) begin
      write_byte(8'(i * 3 + 1), 1'b1);
      if (i == 0) check("write_visible", {22'b0, buffer_count}, 32'd1);
      if (i != START - 1) tick(9);
    end
    check("thr_count", {22'b0, buffer_count}, START);
    check("thr_not_yet", {31'b0, wtrans_active}, 32'd0);
    tick(1);
    check("thr_send", {31'b0, wtrans_active}, 32'd1);
    tick(1);
    check("thr_first_strobe", {31'b0, bus.tx_use_node}, 32'd1);
    wait_strobes(base + START, 400, low);
    check("thr_count_empty", {22'b0, buffer_count}, 32'd0);
    finish_drain("thr");
    check("thr_sb_empty", exp_q.size(), 32'd0);

    // Partial packet: 5 bytes then silence
    base = strobe_cnt;
`ifdef WTX_IDLE_FLUSH_EN
    for (int i = 0; i < 5; i++) write_byte(8'(8'hC0 + i), 1'b1);
    // IDLE_TO idle cycles follow the last write; SEND on the next one.
    tick(IDLE_TO - 1);
    check("idle_not_yet", {31'b0, wtrans_active}, 32'd0);
    tick(1);
    check("idle_send", {31'b0, wtrans_active}, 32'd1);
    tick(1);
    check("idle_first_strobe", {31'b0, bus.tx_use_node}, 32'd1);
    wait_strobes(base + 5, 100, low);
    finish_drain("idle");
`else
    for (int i = 0; i < 5; i++) write_byte(8'(8'hC0 + i), 1'b0);
    tick(IDLE_TO + 200);
    check("noflush_strobes", strobe_cnt - base, 32'd0);
    check("noflush_count", {22'b0, buffer_count}, 32'd5);
    check("noflush_wtrans", {31'b0, wtrans_active}, 32'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_q.delete();
    tick(1);
`endif

    // 130 bytes loaded while disabled: bursts 58, 58, 14 with gaps
    trans_enable = 1'b0;
    base = strobe_cnt;
    for (int i = 0; i < 130; i++) write_byte(8'(i), 1'b1);
    check("multi_count", {22'b0, buffer_count}, 32'd130);
    trans_enable = 1'b1;
    wait_strobes(base + 1, 20, low);
    wait_strobes(base + 130, 3000, low);
    check("multi_wtrans_low", low, 32'd0);
    // One SEND cycle sees the limit, GAP_LEN cycles of GAP, one SEND cycle
    // issues the read, then the registered strobe.
    for (int i = 1; i < 130; i++)
      check("burst_interval", strobe_cyc[base + i] - strobe_cyc[base + i - 1],
            (i == 58 || i == 116) ? GAP_LEN + 2 : 2);
    finish_drain("multi");
    check("multi_sb_empty", exp_q.size(), 32'd0);

    // Overflow with transmit disabled
    trans_enable = 1'b0;
    base = strobe_cnt;
    for (int i = 0; i < 512; i++) write_byte(8'(i), 1'b0);
    check("full_count", {22'b0, buffer_count}, 32'd512);
    check("full_no_ovf", {31'b0, overflow}, 32'd0);
    write_byte(8'hEE, 1'b0);
    check("ovf_count", {22'b0, buffer_count}, 32'd512);
    check("ovf_flag", {31'b0, overflow}, 32'd1);
    check("ovf_no_strobe", strobe_cnt - base, 32'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    check("ovf_rst_flag", {31'b0, overflow}, 32'd0);
    check("ovf_rst_count", {22'b0, buffer_count}, 32'd0);

    // trans_enable drop after 20 bytes, then resume
    trans_enable = 1'b1;
    base = strobe_cnt;
    for (int i = 0; i < START; i++) write_byte(8'(8'h40 + i), 1'b1);
    wait_strobes(base + 20, 200, low);
    trans_enable = 1'b0;
    tick(20);
    check("dis_sent", strobe_cnt - base, 32'd20);
    check("dis_retained", {22'b0, buffer_count}, 32'd38);
    check("dis_drain", {31'b0, wtrans_active}, 32'd1);
    bus.tx_complete_node = 1'b1;
    tick(1);
    bus.tx_complete_node = 1'b0;
    check("dis_collect_wtrans", {31'b0, wtrans_active}, 32'd0);
    check("dis_collect_busy", {31'b0, aux_busy_n}, 32'd0);
    tick(5);
    trans_enable = 1'b1;
    for (int i = 0; i < 20; i++) write_byte(8'(8'h90 + i), 1'b1);
    wait_strobes(base + 78, 400, low);
    finish_drain("dis");
    check("dis_sb_empty", exp_q.size(), 32'd0);

    // Simultaneous write/read, then reset mid-SEND
    bus.tx_ready_node = 1'b0;
    base = strobe_cnt;
    for (int i = 0; i < START; i++) write_byte(8'(8'h10 + i), 1'b1);
    tick(3);
    check("hold_wtrans", {31'b0, wtrans_active}, 32'd1);
    check("hold_no_strobe", strobe_cnt - base, 32'd0);
    bus.tx_ready_node = 1'b1;
    write_byte(8'hA5, 1'b1);
    check("wr_rd_count", {22'b0, buffer_count}, START);
    for (int i = 0; i < 12; i++) begin
      bus.tx_ready_node = ~bus.tx_ready_node;
      tick(1);
    end
    rst = 1'b1;
    tick(1);
    check("mid_rst_tx_use", {31'b0, bus.tx_use_node}, 32'd0);
    check("mid_rst_tx_data", {24'b0, bus.data_to_uart_node}, 32'd0);
    check("mid_rst_wtrans", {31'b0, wtrans_active}, 32'd0);
    check("mid_rst_busy_n", {31'b0, aux_busy_n}, 32'd1);
    check("mid_rst_count", {22'b0, buffer_count}, 32'd0);
    check("mid_rst_overflow", {31'b0, overflow}, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    tick(5);
    check("post_rst_count", {22'b0, buffer_count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
